mem_stage_lsu: RTL

Memory-stage load/store unit; consumes the EX/MEM pipeline register fields (memory controls, address, ALU result, rd, funct3), runs a req/gnt/rvalid transaction on the data-memory bus, and returns an aligned, extended write-back result. Holds the pipeline via `in_ready` while a bus access is outstanding. Sits between the EX/MEM register and the MEM/WB register.

---
 rtl/rv32i_pkg.sv | 52 +++++
 rtl/mem_stage_lsu_load_align.sv | 29 ++
 rtl/mem_stage_lsu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 encodings, LSU states,
// and the store lane/legality helpers used when an entry is accepted.
package rv32i_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } lsu_state_t;

   // funct3[1:0] carries the access size for both loads and stores.
   function automatic logic [3:0] lane_mask(logic [2:0] f3, logic [1:0] addr_lo);
      case (f3[1:0])
         2'd0:    return 4'b0001 << addr_lo;
         2'd1:    return addr_lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(logic [2:0] f3, logic [31:0] sd);
      case (f3[1:0])
         2'd0:    return {4{sd[7:0]}};
         2'd1:    return {2{sd[15:0]}};
         default: return sd;
      endcase
   endfunction

   function automatic logic access_ok(logic rd_en, logic wr_en, logic [2:0] f3,
                                      logic [1:0] addr_lo);
      logic f3_ok;
      logic aligned;
      if (rd_en && wr_en) return 1'b0;
      if (rd_en) f3_ok = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      else       f3_ok = f3 inside {F3_SB, F3_SH, F3_SW};
      case (f3[1:0])
         2'd1:    aligned = !addr_lo[0];
         2'd2:    aligned = (addr_lo == 2'b00);
         default: aligned = 1'b1;
      endcase
      return f3_ok && aligned;
   endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data extraction: picks the addressed byte/half lane out of the bus word
// and sign- or zero-extends it according to funct3.
module load_align
   import rv32i_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
   assign half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   // NOTE: data_o is assigned on every path (default arm), so no latch is inferred.
   always_comb begin
      case (funct3_i)
         F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
         F3_LBU:  data_o = {24'h0, byte_v};
         F3_LH:   data_o = {{16{half_v[15]}}, half_v};
         F3_LHU:  data_o = {16'h0, half_v};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns an EX/MEM entry into one req/gnt/rvalid
// bus transaction and produces a registered, aligned write-back result.
module mem_stage_lsu
   import rv32i_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            mem_read,
   input  logic            mem_write_en,
   input  logic            mem_to_reg,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] alu_val,
   input  logic [4:0]      rd,
   input  logic [2:0]      funct3,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            misalign_err
);

   lsu_state_t      state_q;
   logic            dmem_req_q;
   logic            dmem_we_q;
   logic [XLEN-1:0] dmem_addr_q;
   logic [3:0]      dmem_be_q;
   logic [XLEN-1:0] dmem_wdata_q;
   logic            wb_valid_q;
   logic [4:0]      wb_rd_q;
   logic [XLEN-1:0] wb_data_q;
   logic            misalign_err_q;

   // Context of the outstanding load, needed when rvalid arrives.
   logic [4:0]      rd_q;
   logic [XLEN-1:0] alu_val_q;
   logic            mem_to_reg_q;
   logic [2:0]      funct3_q;
   logic [1:0]      addr_lo_q;

   logic [XLEN-1:0] load_val;

   load_align u_load_align (
      .rdata_i   (dmem_rdata),
      .addr_lo_i (addr_lo_q),
      .funct3_i  (funct3_q),
      .data_o    (load_val)
   );

   // NOTE: all state below uses non-blocking assignments so every flop samples
   // pre-edge values and the block order cannot change behaviour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         dmem_req_q     <= 1'b0;
         dmem_we_q      <= 1'b0;
         dmem_addr_q    <= '0;
         dmem_be_q      <= '0;
         dmem_wdata_q   <= '0;
         wb_valid_q     <= 1'b0;
         wb_rd_q        <= '0;
         wb_data_q      <= '0;
         misalign_err_q <= 1'b0;
         rd_q           <= '0;
         alu_val_q      <= '0;
         mem_to_reg_q   <= 1'b0;
         funct3_q       <= '0;
         addr_lo_q      <= '0;
      end else begin
         wb_valid_q     <= 1'b0;
         misalign_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (!mem_read && !mem_write_en) begin
                     wb_valid_q <= 1'b1;
                     wb_rd_q    <= rd;
                     wb_data_q  <= alu_val;
                  end else if (!access_ok(mem_read, mem_write_en, funct3, mem_addr[1:0])) begin
                     misalign_err_q <= 1'b1;
                  end else begin
                     dmem_req_q   <= 1'b1;
                     dmem_we_q    <= mem_write_en;
                     dmem_addr_q  <= {mem_addr[XLEN-1:2], 2'b00};
                     dmem_be_q    <= lane_mask(funct3, mem_addr[1:0]);
                     dmem_wdata_q <= store_lanes(funct3, store_data);
                     rd_q         <= rd;
                     alu_val_q    <= alu_val;
                     mem_to_reg_q <= mem_to_reg;
                     funct3_q     <= funct3;
                     addr_lo_q    <= mem_addr[1:0];
                     state_q      <= REQ;
                  end
               end
            end
            REQ: begin
               if (dmem_gnt) begin
                  dmem_req_q <= 1'b0;
                  state_q    <= dmem_we_q ? IDLE : RESP;
               end
            end
            RESP: begin
               if (dmem_rvalid) begin
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rd_q;
                  wb_data_q  <= mem_to_reg_q ? load_val : alu_val_q;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready     = (state_q == IDLE);
   assign dmem_req     = dmem_req_q;
   assign dmem_we      = dmem_we_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_be      = dmem_be_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign wb_valid     = wb_valid_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign misalign_err = misalign_err_q;

endmodule
